csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 65 ++++++
 rtl/csr_timer.sv | 83 ++++++++
 rtl/csr_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_csr_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR unit: CSR addresses, exception codes,
// field bit positions and the masked-write helper.
// ---------------------------------------------------------------------------
package csr_pkg;

  // CSR addresses (14-bit CSR number space)
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Exception codes that capture a bad address
  localparam logic [5:0] ECODE_ADEF = 6'h08;  // fetch address error -> BADV = pc
  localparam logic [5:0] ECODE_ALE  = 6'h09;  // misaligned access    -> BADV = vaddr

  // CRMD fields
  localparam int CRMD_PLV_LO = 0;
  localparam int CRMD_PLV_HI = 1;
  localparam int CRMD_IE     = 2;

  // PRMD fields
  localparam int PRMD_PPLV_LO = 0;
  localparam int PRMD_PPLV_HI = 1;
  localparam int PRMD_PIE     = 2;

  // ECFG local interrupt enables; bit 10 is reserved
  localparam int          ECFG_LIE_HI   = 12;
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;

  // ESTAT fields
  localparam int ESTAT_IS_SW_HI  = 1;
  localparam int ESTAT_IS_TI     = 11;
  localparam int ESTAT_IS_IPI    = 12;
  localparam int ESTAT_ECODE_LO  = 16;
  localparam int ESTAT_ECODE_HI  = 21;
  localparam int ESTAT_ESUB_LO   = 22;
  localparam int ESTAT_ESUB_HI   = 30;

  // EENTRY keeps a 64-byte aligned vector base
  localparam int EENTRY_VA_LO = 6;

  // TCFG / TICLR fields
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TCFG_INIT_LO  = 2;
  localparam int TICLR_CLR     = 0;

  // Bits selected by wmask take the new value, the rest keep the old one.
  function automatic logic [31:0] csr_merge(input logic [31:0] old,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// ---------------------------------------------------------------------------
// csr_timer
// Constant-frequency timer behind the TCFG / TVAL / TICLR CSRs and the
// ESTAT.IS[11] timer interrupt flag.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   tcfg_we    write strobe for TCFG this cycle
//   wmask      write mask, TIMER_WIDTH LSBs
//   wvalue     write data, TIMER_WIDTH LSBs
//   ticlr      effective TICLR.CLR write (mask & value bit0) this cycle
//   tcfg       current TCFG register
//   tval       current down-counter
//   timer_int  latched timer interrupt flag (ESTAT.IS[11])
// ---------------------------------------------------------------------------
module csr_timer
  import csr_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tcfg_we,
  input  logic [TIMER_WIDTH-1:0] wmask,
  input  logic [TIMER_WIDTH-1:0] wvalue,
  input  logic                   ticlr,
  output logic [TIMER_WIDTH-1:0] tcfg,
  output logic [TIMER_WIDTH-1:0] tval,
  output logic                   timer_int
);

  logic [TIMER_WIDTH-1:0] tcfg_q;
  logic [TIMER_WIDTH-1:0] tval_q;
  logic                   ti_q;

  logic [TIMER_WIDTH-1:0] tcfg_new;
  logic [TIMER_WIDTH-1:0] load_new;
  logic [TIMER_WIDTH-1:0] reload;
  logic                   fire;

  assign tcfg_new = (wmask & wvalue) | (~wmask & tcfg_q);
  assign load_new = {tcfg_new[TIMER_WIDTH-1:TCFG_INIT_LO], 2'b00};
  assign reload   = {tcfg_q[TIMER_WIDTH-1:TCFG_INIT_LO], 2'b00};

  // A fire is the 1->0 step of the counter. A TCFG write at the same edge
  // reloads the counter instead, so no step happens and nothing fires.
  assign fire = tcfg_q[TCFG_EN] && (tval_q == TIMER_WIDTH'(1)) && !tcfg_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      if (tcfg_we) begin
        tcfg_q <= tcfg_new;
        tval_q <= load_new;
      end else if (tcfg_q[TCFG_EN]) begin
        if (tval_q != '0) begin
          tval_q <= tval_q - 1'b1;
        end else if (tcfg_q[TCFG_PERIODIC]) begin
          // Counter sat at 0 for one cycle after the fire; restart it.
          tval_q <= reload;
        end
      end

      // A fire beats a coincident clear so the event is never lost.
      if (fire) begin
        ti_q <= 1'b1;
      end else if (ticlr) begin
        ti_q <= 1'b0;
      end
    end
  end

  assign tcfg      = tcfg_q;
  assign tval      = tval_q;
  assign timer_int = ti_q;

endmodule

// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
// Control/status register file: mode (CRMD/PRMD), exception config/status,
// exception return address, bad address, entry vector, SAVE scratch
// registers, timer id and the timer (csr_timer).
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   csr_re, csr_num            read enable and CSR address
//   csr_rvalue                 combinational read data (pre-write value)
//   csr_we, csr_wmask,
//   csr_wvalue                 masked write, applied at the next edge
//   wb_ex, wb_ecode,
//   wb_esubcode, wb_pc,
//   wb_vaddr                   exception commit
//   ertn_flush                 exception-return commit
//   hw_int_in, ipi_int_in      interrupt sources, sampled every cycle
//   ex_entry, ertn_entry       exception vector and return address
//   has_int                    enabled interrupt pending while CRMD.IE=1
// ---------------------------------------------------------------------------
module csr_unit
  import csr_pkg::*;
#(
  parameter int          TIMER_WIDTH = 32,
  parameter int          HW_INT_NUM  = 8,
  parameter int          NUM_SAVE    = 4,
  parameter logic [31:0] CORE_ID     = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic                  wb_ex,
  input  logic [5:0]            wb_ecode,
  input  logic [8:0]            wb_esubcode,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_vaddr,
  input  logic                  ertn_flush,
  input  logic [HW_INT_NUM-1:0] hw_int_in,
  input  logic                  ipi_int_in,
  output logic [31:0]           ex_entry,
  output logic [31:0]           ertn_entry,
  output logic                  has_int
);

  localparam int SAVE_IW = (NUM_SAVE > 1) ? $clog2(NUM_SAVE) : 1;

  // Architectural state
  logic [1:0]            crmd_plv;
  logic                  crmd_ie;
  logic [1:0]            prmd_pplv;
  logic                  prmd_pie;
  logic [12:0]           ecfg_lie;
  logic [1:0]            is_sw;
  logic [5:0]            estat_ecode;
  logic [8:0]            estat_esub;
  logic [31:0]           era;
  logic [31:0]           badv;
  logic [31:6]           eentry_va;
  logic [31:0]           save_q [NUM_SAVE];
  logic [31:0]           tid;
  logic [HW_INT_NUM-1:0] hw_q;
  logic                  ipi_q;

  // Timer view
  logic [TIMER_WIDTH-1:0] tcfg;
  logic [TIMER_WIDTH-1:0] tval;
  logic                   timer_int;

  // Address decode
  logic               we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv;
  logic               we_eentry, we_tid, we_tcfg, we_save, ticlr;
  logic [13:0]        save_off;
  logic               save_hit;
  logic [SAVE_IW-1:0] save_idx;
  logic [12:0]        lie_wmask;

  assign save_off = csr_num - CSR_SAVE0;
  assign save_hit = (csr_num >= CSR_SAVE0) && (save_off < 14'(NUM_SAVE));
  assign save_idx = save_off[SAVE_IW-1:0];

  assign we_crmd   = csr_we && (csr_num == CSR_CRMD);
  assign we_prmd   = csr_we && (csr_num == CSR_PRMD);
  assign we_ecfg   = csr_we && (csr_num == CSR_ECFG);
  assign we_estat  = csr_we && (csr_num == CSR_ESTAT);
  assign we_era    = csr_we && (csr_num == CSR_ERA);
  assign we_badv   = csr_we && (csr_num == CSR_BADV);
  assign we_eentry = csr_we && (csr_num == CSR_EENTRY);
  assign we_tid    = csr_we && (csr_num == CSR_TID);
  assign we_tcfg   = csr_we && (csr_num == CSR_TCFG);
  assign we_save   = csr_we && save_hit;
  assign ticlr     = csr_we && (csr_num == CSR_TICLR)
                     && csr_wmask[TICLR_CLR] && csr_wvalue[TICLR_CLR];

  assign lie_wmask = csr_wmask[ECFG_LIE_HI:0] & ECFG_LIE_MASK;

  // Each field takes the highest-priority source that touches it:
  // reset, then exception commit, then ERTN, then a software write.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv    <= '0;
      crmd_ie     <= 1'b0;
      prmd_pplv   <= '0;
      prmd_pie    <= 1'b0;
      ecfg_lie    <= '0;
      is_sw       <= '0;
      estat_ecode <= '0;
      estat_esub  <= '0;
      era         <= '0;
      badv        <= '0;
      eentry_va   <= '0;
      tid         <= CORE_ID;
      // NOTE: the SAVE array is a handful of flops, not a RAM macro, so it is
      // reset like any other register and reads are defined from the start.
      for (int i = 0; i < NUM_SAVE; i++) begin
        save_q[i] <= '0;
      end
    end else begin
      // CRMD.{PLV,IE}
      if (wb_ex) begin
        crmd_plv <= '0;
        crmd_ie  <= 1'b0;
      end else if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (we_crmd) begin
        crmd_plv <= (csr_wmask[CRMD_PLV_HI:CRMD_PLV_LO] & csr_wvalue[CRMD_PLV_HI:CRMD_PLV_LO])
                  | (~csr_wmask[CRMD_PLV_HI:CRMD_PLV_LO] & crmd_plv);
        crmd_ie  <= (csr_wmask[CRMD_IE] & csr_wvalue[CRMD_IE])
                  | (~csr_wmask[CRMD_IE] & crmd_ie);
      end

      // PRMD.{PPLV,PIE}
      if (wb_ex) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
      end else if (we_prmd) begin
        prmd_pplv <= (csr_wmask[PRMD_PPLV_HI:PRMD_PPLV_LO] & csr_wvalue[PRMD_PPLV_HI:PRMD_PPLV_LO])
                   | (~csr_wmask[PRMD_PPLV_HI:PRMD_PPLV_LO] & prmd_pplv);
        prmd_pie  <= (csr_wmask[PRMD_PIE] & csr_wvalue[PRMD_PIE])
                   | (~csr_wmask[PRMD_PIE] & prmd_pie);
      end

      // ECFG.LIE
      if (we_ecfg) begin
        ecfg_lie <= (lie_wmask & csr_wvalue[ECFG_LIE_HI:0]) | (~lie_wmask & ecfg_lie);
      end

      // ESTAT: only the two software interrupt bits are writable
      if (we_estat) begin
        is_sw <= (csr_wmask[ESTAT_IS_SW_HI:0] & csr_wvalue[ESTAT_IS_SW_HI:0])
               | (~csr_wmask[ESTAT_IS_SW_HI:0] & is_sw);
      end
      if (wb_ex) begin
        estat_ecode <= wb_ecode;
        estat_esub  <= wb_esubcode;
      end

      // ERA
      if (wb_ex) begin
        era <= wb_pc;
      end else if (we_era) begin
        era <= csr_merge(era, csr_wmask, csr_wvalue);
      end

      // BADV: only address-error exceptions capture an address
      if (wb_ex) begin
        if (wb_ecode == ECODE_ADEF) begin
          badv <= wb_pc;
        end else if (wb_ecode == ECODE_ALE) begin
          badv <= wb_vaddr;
        end
      end else if (we_badv) begin
        badv <= csr_merge(badv, csr_wmask, csr_wvalue);
      end

      // EENTRY
      if (we_eentry) begin
        eentry_va <= (csr_wmask[31:EENTRY_VA_LO] & csr_wvalue[31:EENTRY_VA_LO])
                   | (~csr_wmask[31:EENTRY_VA_LO] & eentry_va);
      end

      // TID
      if (we_tid) begin
        tid <= csr_merge(tid, csr_wmask, csr_wvalue);
      end

      // SAVEn
      for (int i = 0; i < NUM_SAVE; i++) begin
        if (we_save && (save_idx == SAVE_IW'(i))) begin
          save_q[i] <= csr_merge(save_q[i], csr_wmask, csr_wvalue);
        end
      end
    end
  end

  // Interrupt lines are plain samplers of level inputs; they follow the pins
  // in every cycle, including during reset.
  always_ff @(posedge clk) begin
    hw_q  <= hw_int_in;
    ipi_q <= ipi_int_in;
  end

  csr_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tcfg_we   (we_tcfg),
    .wmask     (csr_wmask[TIMER_WIDTH-1:0]),
    .wvalue    (csr_wvalue[TIMER_WIDTH-1:0]),
    .ticlr     (ticlr),
    .tcfg      (tcfg),
    .tval      (tval),
    .timer_int (timer_int)
  );

  // Read images
  logic [7:0]  hw_is;
  logic [12:0] estat_is;
  logic [31:0] crmd_rd, prmd_rd, ecfg_rd, estat_rd, eentry_rd;
  logic [31:0] rdata;

  assign hw_is    = 8'(hw_q);
  assign estat_is = {ipi_q, timer_int, 1'b0, hw_is, is_sw};

  // DA is hard-wired to 1; PG, DATF and DATM are hard-wired to 0.
  assign crmd_rd   = {28'b0, 1'b1, crmd_ie, crmd_plv};
  assign prmd_rd   = {29'b0, prmd_pie, prmd_pplv};
  assign ecfg_rd   = {19'b0, ecfg_lie};
  assign estat_rd  = {1'b0, estat_esub, estat_ecode, 3'b0, estat_is};
  assign eentry_rd = {eentry_va, 6'b0};

  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (csr_num)
      CSR_CRMD:   rdata = crmd_rd;
      CSR_PRMD:   rdata = prmd_rd;
      CSR_ECFG:   rdata = ecfg_rd;
      CSR_ESTAT:  rdata = estat_rd;
      CSR_ERA:    rdata = era;
      CSR_BADV:   rdata = badv;
      CSR_EENTRY: rdata = eentry_rd;
      CSR_TID:    rdata = tid;
      CSR_TCFG:   rdata = 32'(tcfg);
      CSR_TVAL:   rdata = 32'(tval);
      default: begin
        if (save_hit) begin
          rdata = save_q[save_idx];
        end
      end
    endcase
  end

  assign csr_rvalue = csr_re ? rdata : 32'h0;
  assign ex_entry   = eentry_rd;
  assign ertn_entry = era;
  assign has_int    = crmd_ie & (|(estat_is & ecfg_lie));

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
// Directed self-checking bench for csr_unit. A default-width instance (with a
// non-zero CORE_ID) covers the CSR file, exceptions, interrupts and the
// timer; a TIMER_WIDTH=8 instance covers the narrow timer and reset while
// counting.
// ---------------------------------------------------------------------------
module tb_csr_unit;

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_SAVE4  = 14'h034;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  logic        clk = 1'b0;
  logic        reset, reset8;
  logic        csr_re, csr_we, csr_we8;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex, ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;

  logic [31:0] csr_rvalue, ex_entry, ertn_entry;
  logic        has_int;
  logic [31:0] rvalue8, ex_entry8, ertn_entry8;
  logic        has_int8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  csr_unit #(
    .CORE_ID (32'h0000_00A5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .ertn_flush  (ertn_flush),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .has_int     (has_int)
  );

  csr_unit #(
    .TIMER_WIDTH (8)
  ) dut8 (
    .clk         (clk),
    .reset       (reset8),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (rvalue8),
    .csr_we      (csr_we8),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (1'b0),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .ertn_flush  (1'b0),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry8),
    .ertn_entry  (ertn_entry8),
    .has_int     (has_int8)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
  endtask

  task automatic rd_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    check(tag, csr_rvalue, exp);
  endtask

  task automatic rd8_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    check(tag, rvalue8, exp);
  endtask

  task automatic is11_chk(input string tag, input logic exp);
    csr_re  = 1'b1;
    csr_num = A_ESTAT;
    #1;
    check(tag, {31'b0, csr_rvalue[11]}, {31'b0, exp});
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_num    = num;
    csr_we     = 1'b1;
    csr_wmask  = mask;
    csr_wvalue = val;
    tick();
    csr_we     = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
  endtask

  task automatic wr8(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_num    = num;
    csr_we8    = 1'b1;
    csr_wmask  = mask;
    csr_wvalue = val;
    tick();
    csr_we8    = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
  endtask

  task automatic except(input logic [5:0] ecode, input logic [8:0] esub,
                        input logic [31:0] pc, input logic [31:0] vaddr, input logic ertn);
    wb_ex       = 1'b1;
    wb_ecode    = ecode;
    wb_esubcode = esub;
    wb_pc       = pc;
    wb_vaddr    = vaddr;
    ertn_flush  = ertn;
    tick();
    wb_ex       = 1'b0;
    ertn_flush  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset8 = 1'b1;
    csr_re = 1'b0; csr_we = 1'b0; csr_we8 = 1'b0;
    csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
    ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
    tick();
    tick();
    reset = 1'b0; reset8 = 1'b0;

    // ---- reset state ----
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    rd_chk("rst_crmd", A_CRMD, 32'h0000_0008);
    rd_chk("rst_tid", A_TID, 32'h0000_00A5);
    rd_chk("rst_estat", A_ESTAT, 32'h0);
    rd_chk("rst_tcfg", A_TCFG, 32'h0);
    rd_chk("rst_tval", A_TVAL, 32'h0);
    check("rst_ex_entry", ex_entry, 32'h0);
    rd8_chk("rst8_tid", A_TID, 32'h0);

    // ---- masked write / same-cycle read ----
    csr_num = A_SAVE2; csr_re = 1'b1; csr_we = 1'b1;
    csr_wmask = 32'hFFFF_0000; csr_wvalue = 32'hDEAD_BEEF;
    #1;
    check("save2_write_cycle", csr_rvalue, 32'h0);
    tick();
    csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    rd_chk("save2_after", A_SAVE2, 32'hDEAD_0000);
    rd_chk("save0_untouched", A_SAVE0, 32'h0);
    wr(A_SAVE4, 32'hFFFF_FFFF, 32'h1234_5678);
    rd_chk("save4_unimpl", A_SAVE4, 32'h0);
    wr(A_TICLR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_chk("ticlr_reads0", A_TICLR, 32'h0);
    rd_chk("unimpl_0x2", 14'h002, 32'h0);

    // ---- exception then ERTN ----
    wr(A_CRMD, 32'hFFFF_FFFF, 32'h0000_0007);
    rd_chk("crmd_7", A_CRMD, 32'h0000_000F);
    except(6'h09, 9'h003, 32'h1C00_0100, 32'h0000_1234, 1'b0);
    rd_chk("ex1_prmd", A_PRMD, 32'h0000_0007);
    rd_chk("ex1_crmd", A_CRMD, 32'h0000_0008);
    rd_chk("ex1_era", A_ERA, 32'h1C00_0100);
    rd_chk("ex1_badv", A_BADV, 32'h0000_1234);
    rd_chk("ex1_estat", A_ESTAT, 32'h00C9_0000);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    rd_chk("ertn_crmd", A_CRMD, 32'h0000_000F);
    check("ertn_entry", ertn_entry, 32'h1C00_0100);

    // other ecode holds BADV; ADEF captures pc
    except(6'h0B, 9'h000, 32'h1C00_0300, 32'h0000_9999, 1'b0);
    rd_chk("ex2_badv_hold", A_BADV, 32'h0000_1234);
    rd_chk("ex2_era", A_ERA, 32'h1C00_0300);
    rd_chk("ex2_prmd", A_PRMD, 32'h0000_0007);
    except(6'h08, 9'h000, 32'h1C00_0400, 32'h0000_7777, 1'b0);
    rd_chk("ex3_badv_pc", A_BADV, 32'h1C00_0400);
    rd_chk("ex3_prmd", A_PRMD, 32'h0000_0000);

    // wb_ex beats a coincident ertn_flush
    wr(A_PRMD, 32'hFFFF_FFFF, 32'h0000_0005);
    wr(A_CRMD, 32'hFFFF_FFFF, 32'h0000_0003);
    except(6'h0B, 9'h000, 32'h1C00_0500, 32'h0, 1'b1);
    rd_chk("prio_crmd", A_CRMD, 32'h0000_0008);
    rd_chk("prio_prmd", A_PRMD, 32'h0000_0003);
    rd_chk("prio_estat", A_ESTAT, 32'h000B_0000);

    // constant CRMD fields, EENTRY alignment, ESTAT writable bits
    wr(A_CRMD, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    rd_chk("crmd_const", A_CRMD, 32'h0000_0008);
    wr(A_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8ABC);
    rd_chk("eentry", A_EENTRY, 32'h1C00_8A80);
    check("ex_entry", ex_entry, 32'h1C00_8A80);
    wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_chk("estat_sw", A_ESTAT, 32'h000B_0003);
    wr(A_ESTAT, 32'h0000_0003, 32'h0);
    rd_chk("estat_sw_clr", A_ESTAT, 32'h000B_0000);

    // ---- one-shot timer ----
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0009);
    rd_chk("os_tcfg", A_TCFG, 32'h0000_0009);
    rd_chk("os_tval_load", A_TVAL, 32'h8);
    is11_chk("os_is11_load", 1'b0);
    for (int k = 7; k >= 0; k--) begin
      tick();
      rd_chk("os_tval", A_TVAL, 32'(k));
      is11_chk("os_is11", (k == 0));
    end
    repeat (3) tick();
    rd_chk("os_tval_hold", A_TVAL, 32'h0);
    is11_chk("os_is11_hold", 1'b1);

    // ---- interrupt gate ----
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h0000_0800);
    rd_chk("ecfg_800", A_ECFG, 32'h0000_0800);
    check("gate_ie0", {31'b0, has_int}, 32'h0);
    wr(A_CRMD, 32'h0000_0004, 32'h0000_0004);
    check("gate_ie1", {31'b0, has_int}, 32'h1);
    wr(A_TICLR, 32'hFFFF_FFFF, 32'h1);
    check("gate_cleared", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h01;
    tick();
    check("gate_hw_masked", {31'b0, has_int}, 32'h0);
    rd_chk("hw_estat", A_ESTAT, 32'h000B_0004);
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h0000_0804);
    check("gate_hw_enabled", {31'b0, has_int}, 32'h1);
    hw_int_in = 8'h00;
    tick();
    check("gate_hw_dropped", {31'b0, has_int}, 32'h0);
    ipi_int_in = 1'b1;
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h0000_1000);
    check("gate_ipi", {31'b0, has_int}, 32'h1);
    rd_chk("ipi_estat", A_ESTAT, 32'h000B_1000);
    ipi_int_in = 1'b0;
    wr(A_CRMD, 32'h0000_0004, 32'h0);
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_chk("ecfg_wmask", A_ECFG, 32'h0000_1BFF);
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h0);

    // ---- periodic timer and clear ----
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0007);
    rd_chk("per_tval_load", A_TVAL, 32'h4);
    for (int k = 3; k >= 0; k--) begin
      tick();
      rd_chk("per_tval", A_TVAL, 32'(k));
    end
    is11_chk("per_fire1", 1'b1);
    wr(A_TICLR, 32'h0, 32'h1);
    rd_chk("per_reload", A_TVAL, 32'h4);
    is11_chk("per_ticlr_unmasked", 1'b1);
    wr(A_TICLR, 32'h1, 32'h1);
    rd_chk("per_tval_3", A_TVAL, 32'h3);
    is11_chk("per_cleared", 1'b0);
    wr(A_TVAL, 32'hFFFF_FFFF, 32'h0000_0055);
    rd_chk("tval_readonly", A_TVAL, 32'h2);
    tick();
    rd_chk("per_tval_1", A_TVAL, 32'h1);
    wr(A_TICLR, 32'h1, 32'h1);
    rd_chk("per_fire2_tval", A_TVAL, 32'h0);
    is11_chk("per_fire_beats_clr", 1'b1);
    tick();
    rd_chk("per_reload2", A_TVAL, 32'h4);
    wr(A_TICLR, 32'h1, 32'h1);
    is11_chk("per_later_clr", 1'b0);
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0);
    rd_chk("per_stop_tval", A_TVAL, 32'h0);

    // ---- narrow timer ----
    wr8(A_TCFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd8_chk("n_tcfg", A_TCFG, 32'h0000_00FF);
    rd8_chk("n_tval_load", A_TVAL, 32'h0000_00FC);
    repeat (251) tick();
    rd8_chk("n_tval_1", A_TVAL, 32'h1);
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    rd8_chk("n_rst_tval", A_TVAL, 32'h0);
    rd8_chk("n_rst_estat", A_ESTAT, 32'h0);
    rd8_chk("n_rst_tcfg", A_TCFG, 32'h0);
    repeat (5) tick();
    rd8_chk("n_no_fire", A_ESTAT, 32'h0);
    rd8_chk("n_tval_idle", A_TVAL, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
